rv32i_main: RTL and testbench
=============================

# rv32i_main

Single-cycle RV32I processor core, top level of the design. Fetch, decode, execute, memory access and write-back all complete in one clock cycle. Instruction and data memories are internal. The block has no functional outputs; benches observe state through named internal signals.

## Interface
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words.
- DMEM_DEPTH, 256: data memory depth in 32-bit words.
- IMEM_FILE, "imem.hex": hex image loaded into instruction memory at elaboration with $readmemh.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.

## Operation
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Every other encoding, including FENCE, ECALL and EBREAK, executes as a NOP: no register or memory write, PC+4.
- Immediate generator (se_out) sign-extends the I, S, B, U and J formats per the ISA.
- ALU operation select (alu_sel) is 4-bit.
- Shift amount uses operand bits [4:0].
- All arithmetic is 32-bit modulo; overflow is ignored.
- SLT and SLTU produce a result of 1 or 0.
- Register file: 32x32, two combinational read ports (rdata1, rdata2), one synchronous write port (waddr, wdata, wren).
- Register x0 reads 0 at all times; writes to it are discarded.
- Write-back mux selects, in priority order:
  - PC+4 for JAL and JALR;
  - the load result for LW;
  - the U-immediate for LUI;
  - otherwise alu_out.
- Next PC:
  - PC+4 (add_out = add_in + 4) by default;
  - PC+imm for JAL and for any taken branch;
  - (rs1+imm) with bit 0 cleared for JALR.
- Instruction memory is word-indexed by PC[31:2]. Addresses beyond IMEM_DEPTH wrap modulo depth.
- Data memory is word-indexed by address[31:2]. Address bits [1:0] are ignored for LW and SW. Out-of-range addresses wrap modulo depth.
- Internal signal names, kept for hierarchical debug access: pc, add_in, add_out, rdata1, rdata2, waddr, wdata, wren, alu_sel, alu_out, se_out.
- The register file instance is named Reg_File and holds its storage in array memory[0:31].

## Timing
- Reset asserted (reset=0), immediately and asynchronously:
  - pc = 0;
  - all 32 registers cleared to 0.
- Data memory is not reset. Instruction memory holds the file image.
- While reset is asserted, no register or data-memory writes occur.
- First instruction executes in the first cycle after reset deasserts; the PC updates on that cycle's rising edge.
- Latency: exactly one cycle per instruction, no stalls.
- Register, data-memory and PC updates all commit on the same rising edge.
- Reads are combinational.
- A read of a register in the same cycle it is being written returns the old value. No internal forwarding.
- Reset asserted mid-program aborts the in-flight instruction; no partial write is allowed.

## Configuration
- RV32I_BYTE_MEM_EN defined:
  - adds LB, LH, LBU, LHU, SB, SH;
  - data memory gets 4 byte-write strobes;
  - loads extract and sign- or zero-extend by address[1:0] (halfword uses address[1]).
- RV32I_BYTE_MEM_EN undefined: those encodings are NOPs and memory is word-write only.

## Structure
- Shared package rv32i_pkg holds:
  - opcode localparams;
  - funct3/funct7 constants;
  - the ALU operation enum (4-bit, matching alu_sel);
  - the immediate-format enum;
  - the write-back select enum.
- One natural sub-module: reg_file, instantiated as Reg_File.
- ALU, immediate generator, decoder and memories stay inline in the top level.

## Test plan
- Arithmetic: reset then run "addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2" -> x3=2, x4=8.
- x0 protection: "addi x0,x0,7; add x5,x0,x0" -> Reg_File.memory[0]=0, x5=0.
- Memory: "addi x1,x0,0x55; sw x1,8(x0); lw x2,8(x0)" -> x2=0x55. With the macro: "sb" of 0x80 then "lb" -> 0xFFFFFF80, "lbu" -> 0x80.
- Branch and loop: count x1 from 0 to 10 with bne -> loop exits with x1=10. A not-taken beq advances PC by 4.
- Jumps and upper immediates:
  - jal x1,+8 at PC 0x10 -> x1=0x14, pc=0x18;
  - jalr x0,0(x1) -> pc=0x14;
  - lui x6,0x12345 -> x6=0x12345000;
  - auipc at PC 0x20 with imm 1 -> rd=0x1020.
- Asynchronous reset mid-run: assert reset between clock edges -> pc and all registers read 0 immediately. Execution restarts at address 0 after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcodes, funct codes and decode enums for the rv32i_main core
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_LB   = 3'd0;
  localparam logic [2:0] F3_LH   = 3'd1;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0;
  localparam logic [2:0] F3_SH   = 3'd1;
  localparam logic [2:0] F3_SW   = 3'd2;

  localparam logic [6:0] F7_NORM = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_LOAD, WB_UIMM} wb_sel_e;

  // alt selects SUB/SRA (instr[30]) where the encoding allows it
  function automatic alu_op_e alu_op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_main_reg_file.sv
// rtl/rv32i_main_reg_file.sv - 32x32 register file, two combinational reads, one synchronous write
module reg_file
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        wren_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] memory [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) memory[i] <= '0;
    end else if (wren_i && (waddr_i != 5'd0)) begin
      memory[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : memory[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : memory[raddr2_i];

endmodule

// File: rtl/rv32i_main.sv
// rtl/rv32i_main.sv - single-cycle RV32I core with internal instruction and data memories
// Define RV32I_BYTE_MEM_EN to add LB/LH/LBU/LHU/SB/SH with byte write strobes.
module rv32i_main
  import rv32i_pkg::*;
#(
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256,
  parameter string IMEM_FILE  = "imem.hex"
) (
  input logic clk,
  input logic reset
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] dmem [0:DMEM_DEPTH-1];

  logic [31:0] pc, pc_d, add_in, add_out, instr;
  logic [31:0] rdata1, rdata2, wdata, alu_out, se_out;
  logic [31:0] alu_a, alu_b, load_data, dmem_rword;
  logic [4:0]  waddr;
  logic        wren;
  alu_op_e     alu_sel;
  imm_fmt_e    imm_fmt;
  wb_sel_e     wb_sel;
  logic        a_pc, b_imm, mem_we, is_branch, is_jal, is_jalr, br_taken;
  logic        load_ok, store_ok;
  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] dmem_idx;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  assign imem_idx = IAW'(pc[31:2] % 30'(IMEM_DEPTH));
  assign instr    = imem[imem_idx];
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];

  always_comb begin
    se_out = '0;
    case (imm_fmt)
      IMM_I:   se_out = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   se_out = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   se_out = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   se_out = {instr[31:12], 12'b0};
      IMM_J:   se_out = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: se_out = '0;
    endcase
  end

`ifdef RV32I_BYTE_MEM_EN
  assign load_ok  = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  assign store_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
`else
  assign load_ok  = (funct3 == F3_LW);
  assign store_ok = (funct3 == F3_SW);
`endif

  // Anything not matched below leaves wren/mem_we low and the PC at +4, i.e. a NOP.
  always_comb begin
    imm_fmt   = IMM_I;
    alu_sel   = ALU_ADD;
    a_pc      = 1'b0;
    b_imm     = 1'b0;
    wb_sel    = WB_ALU;
    wren      = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_fmt = IMM_U; wren = 1'b1; wb_sel = WB_UIMM;
      end
      OP_AUIPC: begin
        imm_fmt = IMM_U; a_pc = 1'b1; b_imm = 1'b1; wren = 1'b1;
      end
      OP_JAL: begin
        imm_fmt = IMM_J; is_jal = 1'b1; wren = 1'b1; wb_sel = WB_PC4;
      end
      OP_JALR: begin
        if (funct3 == F3_ADD) begin
          b_imm = 1'b1; is_jalr = 1'b1; wren = 1'b1; wb_sel = WB_PC4;
        end
      end
      OP_BRANCH: begin
        imm_fmt   = IMM_B;
        is_branch = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OP_LOAD: begin
        b_imm = 1'b1;
        if (load_ok) begin
          wren = 1'b1; wb_sel = WB_LOAD;
        end
      end
      OP_STORE: begin
        imm_fmt = IMM_S; b_imm = 1'b1; mem_we = store_ok;
      end
      OP_IMM: begin
        b_imm   = 1'b1;
        alu_sel = alu_op_of(funct3, (funct3 == F3_SR) && instr[30]);
        if (funct3 == F3_SLL)     wren = (funct7 == F7_NORM);
        else if (funct3 == F3_SR) wren = (funct7 == F7_NORM) || (funct7 == F7_ALT);
        else                      wren = 1'b1;
      end
      OP_REG: begin
        alu_sel = alu_op_of(funct3, instr[30]);
        wren    = (funct7 == F7_NORM) ||
                  ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      default: ;
    endcase
  end

  reg_file Reg_File (
    .clk      (clk),
    .rst_n    (reset),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .wren_i   (wren),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign alu_a = a_pc ? pc : rdata1;
  assign alu_b = b_imm ? se_out : rdata2;

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_SLL:  alu_out = alu_a << alu_b[4:0];
      ALU_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_AND:  alu_out = alu_a & alu_b;
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rdata1 == rdata2);
      F3_BNE:  br_taken = (rdata1 != rdata2);
      F3_BLT:  br_taken = ($signed(rdata1) < $signed(rdata2));
      F3_BGE:  br_taken = ($signed(rdata1) >= $signed(rdata2));
      F3_BLTU: br_taken = (rdata1 < rdata2);
      F3_BGEU: br_taken = (rdata1 >= rdata2);
      default: br_taken = 1'b0;
    endcase
  end

  assign dmem_idx   = DAW'(alu_out[31:2] % 30'(DMEM_DEPTH));
  assign dmem_rword = dmem[dmem_idx];

`ifdef RV32I_BYTE_MEM_EN
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be      = 4'b1111;
    st_data = rdata2;
    case (funct3)
      F3_SB: begin
        be = 4'b0001 << alu_out[1:0]; st_data = {4{rdata2[7:0]}};
      end
      F3_SH: begin
        be = alu_out[1] ? 4'b1100 : 4'b0011; st_data = {2{rdata2[15:0]}};
      end
      default: ;
    endcase
  end

  // Data memory has no reset; holding reset low simply suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) dmem[dmem_idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  always_comb begin
    ld_byte   = dmem_rword[{alu_out[1:0], 3'b000} +: 8];
    ld_half   = alu_out[1] ? dmem_rword[31:16] : dmem_rword[15:0];
    load_data = dmem_rword;
    case (funct3)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  load_data = {24'b0, ld_byte};
      F3_LHU:  load_data = {16'b0, ld_half};
      default: load_data = dmem_rword;
    endcase
  end
`else
  always_ff @(posedge clk) begin
    if (reset && mem_we) dmem[dmem_idx] <= rdata2;
  end

  assign load_data = dmem_rword;
`endif

  assign waddr = rd;

  always_comb begin
    wdata = alu_out;
    case (wb_sel)
      WB_PC4:  wdata = add_out;
      WB_LOAD: wdata = load_data;
      WB_UIMM: wdata = se_out;
      default: wdata = alu_out;
    endcase
  end

  assign add_in  = pc;
  assign add_out = add_in + 32'd4;

  always_comb begin
    pc_d = add_out;
    if (is_jal || (is_branch && br_taken)) pc_d = pc + se_out;
    else if (is_jalr)                      pc_d = alu_out & ~32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_d;
  end

endmodule

// File: tb/tb_rv32i_main.sv
// tb/tb_rv32i_main.sv - scoreboard bench for rv32i_main driven by hand-encoded programs
module tb_rv32i_main;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int K_PC   = 0;
  localparam int K_REG  = 1;
  localparam int K_ALLZ = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv32i_main #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .IMEM_FILE("")) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    int unsigned cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog[$];
  int unsigned cyc  = 0;
  int unsigned base = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  exp_t        mon_e;
  logic [31:0] mon_act;
  string       mon_nm;

  initial forever @(posedge clk) cyc++;

  // Monitor: at each falling edge, retire every expectation due by this cycle.
  initial forever begin
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_act = '0;
      case (mon_e.kind)
        K_PC: begin
          mon_act = dut.pc; mon_nm = "pc";
        end
        K_REG: begin
          mon_act = dut.Reg_File.memory[mon_e.idx]; mon_nm = $sformatf("x%0d", mon_e.idx);
        end
        default: begin
          mon_act = dut.pc;
          for (int r = 0; r < 32; r++) mon_act = mon_act | dut.Reg_File.memory[r];
          mon_nm = "pc_or_regs";
        end
      endcase
      n_tests++;
      if (mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s at cycle %0d: got %h expected %h", mon_nm, cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic expect_at(input int k, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.cyc = base + k; e.kind = kind; e.idx = idx; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic start_prog();
    @(negedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = NOP;
    foreach (prog[i]) dut.imem[i] = prog[i];
    base = cyc;
    expect_at(1, K_ALLZ, 0, 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    base  = cyc;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // arithmetic
    prog = '{32'h00500093, 32'hFFD00113, 32'h002081B3, 32'h40208233};
    start_prog();
    expect_at(4, K_REG, 1, 32'd5);
    expect_at(4, K_REG, 2, 32'hFFFFFFFD);
    expect_at(4, K_REG, 3, 32'd2);
    expect_at(4, K_REG, 4, 32'd8);
    expect_at(4, K_PC, 0, 32'h10);
    run(4);

    // x0 protection and an ECALL executing as a NOP
    prog = '{32'h00900293, 32'h00700013, 32'h000002B3, 32'h00000073};
    start_prog();
    expect_at(1, K_REG, 5, 32'd9);
    expect_at(3, K_REG, 0, 32'd0);
    expect_at(3, K_REG, 5, 32'd0);
    expect_at(4, K_PC, 0, 32'h10);
    run(4);

    // word memory, address wrap and ignored low address bits
    prog = '{32'h05500093, 32'h00102423, 32'h00802103, 32'h40802183, 32'h00A02203};
    start_prog();
    expect_at(3, K_REG, 2, 32'h55);
    expect_at(4, K_REG, 3, 32'h55);
    expect_at(5, K_REG, 4, 32'h55);
    run(5);

    // byte store then signed/unsigned byte loads
    prog = '{32'h08000093, 32'h00100223, 32'h00400103, 32'h00404183};
    start_prog();
`ifdef RV32I_BYTE_MEM_EN
    expect_at(4, K_REG, 2, 32'hFFFFFF80);
    expect_at(4, K_REG, 3, 32'h00000080);
`else
    expect_at(4, K_REG, 2, 32'h0);
    expect_at(4, K_REG, 3, 32'h0);
`endif
    expect_at(4, K_PC, 0, 32'h10);
    run(4);

    // bne loop to 10, then a not-taken beq
    prog = '{32'h00A00113, 32'h00108093, 32'hFE209EE3, 32'h00008463, 32'h00100193};
    start_prog();
    expect_at(21, K_REG, 1, 32'd10);
    expect_at(21, K_PC, 0, 32'h0C);
    expect_at(22, K_PC, 0, 32'h10);
    expect_at(23, K_REG, 3, 32'd1);
    run(23);

    // compare, shift and logic ops plus signed/unsigned branches
    prog = '{32'hFFD00093, 32'h00500113, 32'h0020A1B3, 32'h0020B233, 32'h4020D2B3,
             32'h0020D333, 32'h002113B3, 32'hFFF0C413, 32'h0020C463, 32'h00100493,
             32'h0020E463, 32'h00700513};
    start_prog();
    expect_at(9, K_PC, 0, 32'h28);
    expect_at(10, K_PC, 0, 32'h2C);
    expect_at(11, K_REG, 3, 32'd1);
    expect_at(11, K_REG, 4, 32'd0);
    expect_at(11, K_REG, 5, 32'hFFFFFFFF);
    expect_at(11, K_REG, 6, 32'h07FFFFFF);
    expect_at(11, K_REG, 7, 32'hA0);
    expect_at(11, K_REG, 8, 32'd2);
    expect_at(11, K_REG, 9, 32'd0);
    expect_at(11, K_REG, 10, 32'd7);
    run(11);

    // jal / jalr / lui
    prog = '{NOP, NOP, NOP, NOP, 32'h008000EF, 32'h12345337, 32'h00008067};
    start_prog();
    expect_at(5, K_REG, 1, 32'h14);
    expect_at(5, K_PC, 0, 32'h18);
    expect_at(6, K_PC, 0, 32'h14);
    expect_at(6, K_REG, 0, 32'h0);
    expect_at(7, K_REG, 6, 32'h12345000);
    run(7);

    // auipc, jalr with odd target, instruction fetch wrap
    prog = '{NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP, 32'h00001397, 32'h00138467};
    start_prog();
    expect_at(9, K_REG, 7, 32'h1020);
    expect_at(10, K_PC, 0, 32'h1020);
    expect_at(10, K_REG, 8, 32'h28);
    expect_at(11, K_REG, 7, 32'h2020);
    run(11);

    // asynchronous reset between edges, then restart from address 0
    prog = '{32'h00A00113, 32'h00108093, 32'hFE209EE3};
    start_prog();
    expect_at(5, K_REG, 1, 32'd2);
    expect_at(5, K_PC, 0, 32'h4);
    run(5);
    @(posedge clk); #2;
    reset = 1'b0;
    base  = cyc;
    expect_at(0, K_ALLZ, 0, 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    base  = cyc;
    expect_at(1, K_PC, 0, 32'h4);
    expect_at(1, K_REG, 2, 32'd10);
    expect_at(1, K_REG, 1, 32'd0);
    run(1);

    run(2);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
